// File: rtl/i2c_txn_arbiter_if.sv
// Client request/response and I2C master command signals for i2c_txn_arbiter.
// master: arbiter side. slave: clients plus byte-write master side.
interface i2c_txn_arbiter_if;
  logic       rq0_req;
  logic       rq1_req;
  logic [6:0] rq0_addr;
  logic [6:0] rq1_addr;
  logic [7:0] rq0_data;
  logic [7:0] rq1_data;
  logic       rq0_ack;
  logic       rq1_ack;
  logic       rq0_done;
  logic       rq1_done;
  logic       rq0_nack;
  logic       rq1_nack;
  logic       m_start;
  logic [6:0] m_addr;
  logic [7:0] m_data;
  logic       m_busy;
  logic       m_done;
  logic       m_nack;
  logic       m_abort;
  logic       grant_id;
  logic       arb_busy;

  modport master (
    input  rq0_req, rq1_req, rq0_addr, rq1_addr, rq0_data, rq1_data,
    input  m_busy, m_done, m_nack,
    output rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_nack, rq1_nack,
    output m_start, m_addr, m_data, m_abort, grant_id, arb_busy
  );

  modport slave (
    output rq0_req, rq1_req, rq0_addr, rq1_addr, rq0_data, rq1_data,
    output m_busy, m_done, m_nack,
    input  rq0_ack, rq1_ack, rq0_done, rq1_done, rq0_nack, rq1_nack,
    input  m_start, m_addr, m_data, m_abort, grant_id, arb_busy
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin two-client arbiter/sequencer for the shared I2C byte-write master.
// Optional WAIT_DONE watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_txn_arbiter #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic             i_Clk,
  input  logic             reset,
  i2c_txn_arbiter_if.master bus
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, RESP, GAP} state_t;

  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t        state_q;
  logic          last_grant_q;
  logic          grant_id_q;
  logic          status_q;
  logic [GW-1:0] gap_q;
  logic [6:0]    addr_q;
  logic [7:0]    data_q;
  logic          ack0_q, ack1_q, done0_q, done1_q, nack0_q, nack1_q;
  logic          start_q, busy_q;
  logic          pick;

  // On a tie the requester that did not win last time goes next.
  assign pick = (bus.rq0_req && bus.rq1_req) ? ~last_grant_q : bus.rq1_req;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt_q;
  logic          abort_q;
  assign bus.m_abort = abort_q;
`else
  assign bus.m_abort = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      status_q     <= 1'b0;
      gap_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      nack0_q      <= 1'b0;
      nack1_q      <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      abort_q      <= 1'b0;
`endif
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      nack0_q <= 1'b0;
      nack1_q <= 1'b0;
      start_q <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      abort_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if ((bus.rq0_req || bus.rq1_req) && !bus.m_busy) begin
            addr_q       <= pick ? bus.rq1_addr : bus.rq0_addr;
            data_q       <= pick ? bus.rq1_data : bus.rq0_data;
            ack0_q       <= ~pick;
            ack1_q       <= pick;
            grant_id_q   <= pick;
            last_grant_q <= pick;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          start_q <= 1'b1;
`ifdef I2C_ARB_TIMEOUT_EN
          to_cnt_q <= '0;
`endif
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A completion on the expiry edge wins over the watchdog.
          if (bus.m_done) begin
            status_q <= bus.m_nack;
            state_q  <= RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            abort_q  <= 1'b1;
            status_q <= 1'b1;
            state_q  <= RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
`endif
        end
        RESP: begin
          done0_q <= ~grant_id_q;
          done1_q <= grant_id_q;
          nack0_q <= ~grant_id_q & status_q;
          nack1_q <= grant_id_q & status_q;
          gap_q   <= '0;
          if (GAP_CYCLES == 0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            state_q <= GAP;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            gap_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.rq0_ack  = ack0_q;
  assign bus.rq1_ack  = ack1_q;
  assign bus.rq0_done = done0_q;
  assign bus.rq1_done = done1_q;
  assign bus.rq0_nack = nack0_q;
  assign bus.rq1_nack = nack1_q;
  assign bus.m_start  = start_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_data   = data_q;
  assign bus.grant_id = grant_id_q;
  assign bus.arb_busy = busy_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: grants and completions are predicted
// when requests are driven and consumed as the arbiter produces them.
module tb_i2c_txn_arbiter;
  localparam int G  = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset;

  i2c_txn_arbiter_if bus_if();

  i2c_txn_arbiter #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) dut (
    .i_Clk(clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial forever #5 clk = ~clk;

  typedef struct {bit id; logic [6:0] addr; logic [7:0] data;} grant_t;
  typedef struct {bit id; bit nack;} done_t;

  grant_t exp_g[$];
  done_t  exp_d[$];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int ack_cyc = -10, done_cyc = 0, last_gap = 0, start_cyc = 0, n_done = 0;
  bit done_seen = 0, ack_flag = 0, done_flag = 0, start_flag = 0, last_ack_id = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] outs();
    return {bus_if.rq0_ack, bus_if.rq1_ack, bus_if.rq0_done, bus_if.rq1_done,
            bus_if.rq0_nack, bus_if.rq1_nack, bus_if.m_start, bus_if.m_addr,
            bus_if.m_data, bus_if.m_abort, bus_if.grant_id, bus_if.arb_busy};
  endfunction

  task automatic observe();
    grant_t g;
    done_t  d;
    ack_flag   = 0;
    done_flag  = 0;
    start_flag = bus_if.m_start;
    if (bus_if.rq0_ack || bus_if.rq1_ack) begin
      ack_flag    = 1;
      last_ack_id = bus_if.rq1_ack;
      if (exp_g.size() == 0) check_val("ack_unexpected", {bus_if.rq1_ack, bus_if.rq0_ack}, 0);
      else begin
        g = exp_g.pop_front();
        check_val("ack_owner", {bus_if.rq1_ack, bus_if.rq0_ack}, g.id ? 2 : 1);
        check_val("ack_addr", bus_if.m_addr, g.addr);
        check_val("ack_data", bus_if.m_data, g.data);
        check_val("grant_id", bus_if.grant_id, g.id);
      end
      if (done_seen) begin
        last_gap  = cyc - done_cyc;
        done_seen = 0;
      end
      ack_cyc = cyc;
    end
    if (bus_if.m_start || cyc == ack_cyc + 1)
      check_val("start_lat", bus_if.m_start, cyc == ack_cyc + 1);
    if (bus_if.rq0_done || bus_if.rq1_done) begin
      done_flag = 1;
      n_done++;
      if (exp_d.size() == 0) check_val("done_unexpected", {bus_if.rq1_done, bus_if.rq0_done}, 0);
      else begin
        d = exp_d.pop_front();
        check_val("done_owner", {bus_if.rq1_done, bus_if.rq0_done}, d.id ? 2 : 1);
        check_val("done_nack", {bus_if.rq1_nack, bus_if.rq0_nack}, d.nack ? (d.id ? 2 : 1) : 0);
      end
      done_cyc  = cyc;
      done_seen = 1;
    end else if (bus_if.rq0_nack || bus_if.rq1_nack) begin
      check_val("nack_stray", {bus_if.rq1_nack, bus_if.rq0_nack}, 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    observe();
  endtask

  task automatic wait_ack(input int lim);
    bit got = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (ack_flag) begin got = 1; break; end
    end
    if (!got) check_val("ack_timeout", 0, 1);
  endtask

  task automatic wait_start(input int lim);
    bit got = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (start_flag) begin got = 1; start_cyc = cyc; break; end
    end
    if (!got) check_val("start_timeout", 0, 1);
  endtask

  task automatic wait_done(input int lim);
    bit got = 0;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done_flag) begin got = 1; break; end
    end
    if (!got) check_val("done_timeout", 0, 1);
  endtask

  task automatic serve(input int dly, input bit nack);
    repeat (dly) tick();
    bus_if.m_done = 1'b1;
    bus_if.m_nack = nack;
    tick();
    bus_if.m_done = 1'b0;
    bus_if.m_nack = 1'b0;
    wait_done(20);
  endtask

  initial begin
    int nd0;
    reset          = 1'b1;
    bus_if.rq0_req = 1'b0;  bus_if.rq1_req = 1'b0;
    bus_if.rq0_addr = '0;   bus_if.rq1_addr = '0;
    bus_if.rq0_data = '0;   bus_if.rq1_data = '0;
    bus_if.m_busy  = 1'b0;  bus_if.m_done  = 1'b0;  bus_if.m_nack = 1'b0;

    // reset and single request
    repeat (3) tick();
    check_val("reset_outs", outs(), 0);
    reset = 1'b0;
    tick();
    exp_g.push_back('{1'b0, 7'h3C, 8'hA5});
    exp_d.push_back('{1'b0, 1'b0});
    bus_if.rq0_req = 1'b1; bus_if.rq0_addr = 7'h3C; bus_if.rq0_data = 8'hA5;
    tick();
    check_val("ack_lat", bus_if.rq0_ack, 1);
    bus_if.rq0_req = 1'b0;
    tick();
    check_val("start_after_ack", bus_if.m_start, 1);
    check_val("busy_in_txn", bus_if.arb_busy, 1);
    serve(50, 1'b0);
    tick();
    check_val("done_single_pulse", bus_if.rq0_done, 0);
    check_val("addr_stable", {bus_if.m_addr, bus_if.m_data}, {7'h3C, 8'hA5});

    // NACK from the slave on requester 1
    exp_g.push_back('{1'b1, 7'h50, 8'h11});
    exp_d.push_back('{1'b1, 1'b1});
    bus_if.rq1_req = 1'b1; bus_if.rq1_addr = 7'h50; bus_if.rq1_data = 8'h11;
    wait_ack(50);
    bus_if.rq1_req = 1'b0;
    wait_start(5);
    serve(10, 1'b1);

    // tie with both requests continuously pending
    exp_g.push_back('{1'b0, 7'h10, 8'h00}); exp_d.push_back('{1'b0, 1'b0});
    exp_g.push_back('{1'b1, 7'h11, 8'h01}); exp_d.push_back('{1'b1, 1'b0});
    bus_if.rq0_req = 1'b1; bus_if.rq0_addr = 7'h10; bus_if.rq0_data = 8'h00;
    bus_if.rq1_req = 1'b1; bus_if.rq1_addr = 7'h11; bus_if.rq1_data = 8'h01;
    for (int i = 0; i < 4; i++) begin
      wait_ack(50);
      check_val("rr_order", last_ack_id, i % 2);
      if (i > 0) check_val("rr_gap", last_gap, G + 1);
      if (i < 2) begin
        if (last_ack_id) begin
          bus_if.rq1_addr = 7'h21; bus_if.rq1_data = 8'h02;
          exp_g.push_back('{1'b1, 7'h21, 8'h02}); exp_d.push_back('{1'b1, 1'b0});
        end else begin
          bus_if.rq0_addr = 7'h20; bus_if.rq0_data = 8'h03;
          exp_g.push_back('{1'b0, 7'h20, 8'h03}); exp_d.push_back('{1'b0, 1'b0});
        end
      end else if (last_ack_id) bus_if.rq1_req = 1'b0;
      else bus_if.rq0_req = 1'b0;
      wait_start(5);
      serve(5, 1'b0);
    end

    // busy hold-off
    exp_g.push_back('{1'b0, 7'h22, 8'h33});
    exp_d.push_back('{1'b0, 1'b0});
    bus_if.m_busy  = 1'b1;
    bus_if.rq0_req = 1'b1; bus_if.rq0_addr = 7'h22; bus_if.rq0_data = 8'h33;
    begin
      int acks = 0;
      repeat (100) begin
        tick();
        if (ack_flag) acks++;
      end
      check_val("busy_hold", acks, 0);
    end
    bus_if.m_busy = 1'b0;
    tick();
    check_val("busy_release", bus_if.rq0_ack, 1);
    bus_if.rq0_req = 1'b0;
    wait_start(5);
    serve(3, 1'b0);

    // reset while waiting for the master
    exp_g.push_back('{1'b0, 7'h44, 8'h55});
    bus_if.rq0_req = 1'b1; bus_if.rq0_addr = 7'h44; bus_if.rq0_data = 8'h55;
    wait_ack(50);
    bus_if.rq0_req = 1'b0;
    wait_start(5);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_val("midrst_outs", outs(), 0);
    check_val("midrst_busy", bus_if.arb_busy, 0);
    reset = 1'b0;
    nd0 = n_done;
    bus_if.m_done = 1'b1; bus_if.m_nack = 1'b1;
    tick();
    bus_if.m_done = 1'b0; bus_if.m_nack = 1'b0;
    repeat (10) tick();
    check_val("stale_done", n_done - nd0, 0);

    // after reset the pointer favours requester 0 on a tie
    exp_g.push_back('{1'b0, 7'h01, 8'h0A}); exp_d.push_back('{1'b0, 1'b0});
    exp_g.push_back('{1'b1, 7'h02, 8'h0B}); exp_d.push_back('{1'b1, 1'b0});
    bus_if.rq0_req = 1'b1; bus_if.rq0_addr = 7'h01; bus_if.rq0_data = 8'h0A;
    bus_if.rq1_req = 1'b1; bus_if.rq1_addr = 7'h02; bus_if.rq1_data = 8'h0B;
    wait_ack(10);
    check_val("rst_tie", last_ack_id, 0);
    bus_if.rq0_req = 1'b0;
    wait_start(5);
    serve(4, 1'b0);
    wait_ack(50);
    bus_if.rq1_req = 1'b0;
    wait_start(5);
    serve(4, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
    // watchdog: master never completes
    exp_g.push_back('{1'b1, 7'h66, 8'h77});
    exp_d.push_back('{1'b1, 1'b1});
    bus_if.rq1_req = 1'b1; bus_if.rq1_addr = 7'h66; bus_if.rq1_data = 8'h77;
    wait_ack(50);
    bus_if.rq1_req = 1'b0;
    wait_start(5);
    begin
      bit seen = 0;
      for (int i = 0; i < TO + 50; i++) begin
        tick();
        if (bus_if.m_abort) begin
          seen = 1;
          check_val("abort_lat", cyc - start_cyc, TO);
          break;
        end
      end
      if (!seen) check_val("abort_timeout", 0, 1);
    end
    wait_done(10);
`endif

    repeat (G + 3) tick();
    check_val("abort_idle", bus_if.m_abort, 0);
    check_val("idle_busy", bus_if.arb_busy, 0);
    check_val("scoreboard_empty", exp_g.size() + exp_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
